pipe_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined CPU core. It keeps a small scoreboard of every in-flight instruction that lies past decode (EX, MEM, WB by default). For the instruction in ID it decides, each step, one of three outcomes:
- stall (load-use);
- insert a bubble on redirect (jump/branch);
- proceed, with registered forwarding selects that line up with the operand muxes in EX.

It replaces the fixed three-stage hazard detector and forward unit pair with one block that is generic in pipeline depth, load latency and register-id width.

---
 rtl/pipe_hazard_unit.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Hazard and forwarding controller for the pipelined CPU core. A scoreboard
//   tracks every in-flight instruction past ID (stage 1 = EX .. STAGES = WB).
//   For the instruction in ID it raises a load-use stall, flushes IF/ID on a
//   redirect, and registers the forwarding selects used by the EX operand muxes.
//
//   Optional feature: define HAZARD_STATS_EN to build the saturating
//   stall/flush statistics counters; otherwise both count ports read 0.
//
// Ports
//   CLK, RST          clock, asynchronous active-low reset
//   adv               pipeline advance enable
//   id_valid          ID holds a real instruction
//   id_src1/2         source register ids, id_src1/2_used: operand is read
//   id_dst, id_we     destination register id and write enable
//   id_is_load        result comes from memory
//   redirect          jump/taken branch; the ID instruction is wrong-path
//   stall             hold PC and IF/ID, bubble into EX
//   flush_ifid        replace IF/ID with a NOP on this advance
//   ex_fwd1/2_sel     EX operand source: 0 = ID read value, k = result of stage k
//   stall_cnt         advances taken while stalled
//   flush_cnt         advances taken while flushing
module pipe_hazard_unit #(
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int REG_W      = 4,
    parameter int SEL_W      = $clog2(STAGES + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             adv,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             redirect,
    output logic             stall,
    output logic             flush_ifid,
    output logic [SEL_W-1:0] ex_fwd1_sel,
    output logic [SEL_W-1:0] ex_fwd2_sel,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
);

    localparam int unsigned NS = unsigned'(STAGES);
    localparam int unsigned LS = unsigned'(LOAD_STAGE);

    logic [STAGES:1] e_valid;
    logic [STAGES:1] e_we;
    logic [STAGES:1] e_load;
    logic [REG_W-1:0] e_dst [1:STAGES];

    logic [SEL_W-1:0] m1, m2;
    logic             lu1, lu2;
    logic [SEL_W-1:0] nxt_sel1, nxt_sel2;
    logic             bubble;

    // Scan from the oldest stage down to EX so the youngest matching
    // producer (smallest k) is the one that sticks.
    always_comb begin
        m1  = '0;
        m2  = '0;
        lu1 = 1'b0;
        lu2 = 1'b0;
        for (int unsigned k = NS; k > 0; k--) begin
            if (e_valid[k] && e_we[k] && id_src1_used && (e_dst[k] == id_src1)) begin
                m1  = SEL_W'(k);
                // Load data exists only past LOAD_STAGE; the consumer in EX
                // would see the load at stage k+1, so k+1 <= LOAD_STAGE is too early.
                lu1 = e_load[k] && (k < LS);
            end
            if (e_valid[k] && e_we[k] && id_src2_used && (e_dst[k] == id_src2)) begin
                m2  = SEL_W'(k);
                lu2 = e_load[k] && (k < LS);
            end
        end
    end

    // A producer in the last stage has already written the register file
    // (write-before-read), so the ID read value is current.
    always_comb begin
        nxt_sel1 = '0;
        nxt_sel2 = '0;
        if ((m1 != '0) && (m1 < SEL_W'(NS))) nxt_sel1 = m1 + SEL_W'(1);
        if ((m2 != '0) && (m2 < SEL_W'(NS))) nxt_sel2 = m2 + SEL_W'(1);
    end

    assign stall      = id_valid & (lu1 | lu2) & ~redirect;
    assign flush_ifid = redirect;
    assign bubble     = redirect | stall | ~id_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            e_valid     <= '0;
            e_we        <= '0;
            e_load      <= '0;
            for (int unsigned k = 1; k <= NS; k++) e_dst[k] <= '0;
            ex_fwd1_sel <= '0;
            ex_fwd2_sel <= '0;
        end else if (adv) begin
            for (int unsigned k = NS; k > 1; k--) begin
                e_valid[k] <= e_valid[k-1];
                e_we[k]    <= e_we[k-1];
                e_load[k]  <= e_load[k-1];
                e_dst[k]   <= e_dst[k-1];
            end
            if (bubble) begin
                e_valid[1]  <= 1'b0;
                e_we[1]     <= 1'b0;
                e_load[1]   <= 1'b0;
                e_dst[1]    <= '0;
                ex_fwd1_sel <= '0;
                ex_fwd2_sel <= '0;
            end else begin
                e_valid[1]  <= 1'b1;
                e_we[1]     <= id_we;
                e_load[1]   <= id_is_load;
                e_dst[1]    <= id_dst;
                ex_fwd1_sel <= nxt_sel1;
                ex_fwd2_sel <= nxt_sel2;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (adv) begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
            if (flush_ifid && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Testbench for pipe_hazard_unit (default parameters). Directed scenarios plus
// randomized traffic checked against an in-flight instruction list model.
module tb_pipe_hazard_unit;

    localparam int NST = 3;
    localparam int LST = 2;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       adv = 1'b0;
    logic       id_valid = 1'b0;
    logic [3:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
    logic       id_src1_used = 1'b0, id_src2_used = 1'b0;
    logic       id_we = 1'b0, id_is_load = 1'b0, redirect = 1'b0;
    logic       stall, flush_ifid;
    logic [1:0] ex_fwd1_sel, ex_fwd2_sel;
    logic [15:0] stall_cnt, flush_cnt;

    int n_pass = 0;
    int n_total = 0;

    pipe_hazard_unit dut (
        .CLK(CLK), .RST(RST), .adv(adv), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load),
        .redirect(redirect), .stall(stall), .flush_ifid(flush_ifid),
        .ex_fwd1_sel(ex_fwd1_sel), .ex_fwd2_sel(ex_fwd2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference model: list of in-flight instructions, slot i = i advances past ID.
    typedef struct {
        bit         v;
        bit         we;
        bit         ld;
        logic [3:0] dst;
    } inst_t;

    inst_t      flight [1:NST];
    int         m_sel1, m_sel2;
    int         m_scnt, m_fcnt;

    function automatic int producer(input logic [3:0] src, input bit used);
        if (!used) return 0;
        for (int i = 1; i <= NST; i++)
            if (flight[i].v && flight[i].we && flight[i].dst == src) return i;
        return 0;
    endfunction

    // Load value becomes usable only after it leaves LOAD_STAGE; the consumer
    // in EX would meet the load one stage further on.
    function automatic bit too_early(input int p);
        return (p != 0) && flight[p].ld && (p + 1 <= LST);
    endfunction

    function automatic bit exp_stall();
        int p1, p2;
        p1 = producer(id_src1, id_src1_used);
        p2 = producer(id_src2, id_src2_used);
        return id_valid && (too_early(p1) || too_early(p2)) && !redirect;
    endfunction

    function automatic int fwd_of(input int p);
        return (p >= 1 && p < NST) ? p + 1 : 0;
    endfunction

    task automatic model_clear();
        for (int i = 1; i <= NST; i++) flight[i] = '{v: 1'b0, we: 1'b0, ld: 1'b0, dst: 4'd0};
        m_sel1 = 0; m_sel2 = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic drive(input bit v, input logic [3:0] s1, input bit u1,
                         input logic [3:0] s2, input bit u2,
                         input logic [3:0] d, input bit we, input bit ld, input bit rd);
        id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
        id_dst = d; id_we = we; id_is_load = ld; redirect = rd;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock with the given adv; the model moves in step with the DUT.
    task automatic tick(input bit a);
        bit st;
        int p1, p2;
        adv = a;
        st = exp_stall();
        p1 = producer(id_src1, id_src1_used);
        p2 = producer(id_src2, id_src2_used);
        @(posedge CLK);
        #1;
        if (a) begin
            if (st && m_scnt < 65535) m_scnt++;
            if (redirect && m_fcnt < 65535) m_fcnt++;
            for (int i = NST; i > 1; i--) flight[i] = flight[i-1];
            if (redirect || st || !id_valid) begin
                flight[1] = '{v: 1'b0, we: 1'b0, ld: 1'b0, dst: 4'd0};
                m_sel1 = 0; m_sel2 = 0;
            end else begin
                flight[1] = '{v: 1'b1, we: id_we, ld: id_is_load, dst: id_dst};
                m_sel1 = fwd_of(p1); m_sel2 = fwd_of(p2);
            end
        end
        adv = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (NST) tick(1);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        model_clear();
        idle();
        #3;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else n_pass++;
        n_total++; if (flush_ifid !== 1'b0) $display("FAIL reset_flush got %0b want 0", flush_ifid); else n_pass++;
        n_total++; if (ex_fwd1_sel !== 2'd0 || ex_fwd2_sel !== 2'd0)
            $display("FAIL reset_sel got %0d/%0d want 0/0", ex_fwd1_sel, ex_fwd2_sel); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_alu_back_to_back();
        drive(1, 4'd5, 1, 4'd6, 1, 4'd1, 1, 0, 0);      // ADD r1
        tick(1);
        drive(1, 4'd7, 1, 4'd1, 1, 4'd2, 1, 0, 0);      // ADD r2, r7, r1
        n_total++; if (stall !== 1'b0) $display("FAIL alu_b2b_stall got %0b want 0", stall); else n_pass++;
        tick(1);
        n_total++; if (ex_fwd2_sel !== 2'd2) $display("FAIL alu_b2b_sel2 got %0d want 2", ex_fwd2_sel); else n_pass++;
        n_total++; if (ex_fwd1_sel !== 2'd0) $display("FAIL alu_b2b_sel1 got %0d want 0", ex_fwd1_sel); else n_pass++;
        drain();
    endtask

    task automatic test_load_use();
        drive(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0);      // LW r3
        tick(1);
        drive(1, 4'd3, 1, 4'd8, 0, 4'd4, 1, 0, 0);      // reads r3
        n_total++; if (stall !== 1'b1) $display("FAIL load_use_stall got %0b want 1", stall); else n_pass++;
        tick(1);
        n_total++; if (stall !== 1'b0) $display("FAIL load_use_release got %0b want 0", stall); else n_pass++;
        n_total++; if (ex_fwd1_sel !== 2'd0) $display("FAIL load_use_bubble_sel got %0d want 0", ex_fwd1_sel); else n_pass++;
        tick(1);
        n_total++; if (ex_fwd1_sel !== 2'd3) $display("FAIL load_use_sel1 got %0d want 3", ex_fwd1_sel); else n_pass++;
        drain();
    endtask

    task automatic test_distance();
        drive(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0);      // ADD r4
        tick(1);
        idle();
        tick(1);
        drive(1, 4'd9, 0, 4'd4, 1, 4'd5, 1, 0, 0);      // distance 2: producer at stage 2
        n_total++; if (stall !== 1'b0) $display("FAIL dist2_stall got %0b want 0", stall); else n_pass++;
        tick(1);
        n_total++; if (ex_fwd2_sel !== 2'd3) $display("FAIL dist2_sel2 got %0d want 3", ex_fwd2_sel); else n_pass++;
        drain();
        drive(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 1, 0);      // LW r4
        tick(1);
        idle();
        tick(1);
        tick(1);
        drive(1, 4'd9, 0, 4'd4, 1, 4'd5, 1, 0, 0);      // distance 3: load in WB
        n_total++; if (stall !== 1'b0) $display("FAIL dist3_stall got %0b want 0", stall); else n_pass++;
        tick(1);
        n_total++; if (ex_fwd2_sel !== 2'd0) $display("FAIL dist3_sel2 got %0d want 0", ex_fwd2_sel); else n_pass++;
        drain();
    endtask

    task automatic test_redirect_load();
        drive(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0);      // LW r3
        tick(1);
        drive(1, 4'd3, 1, 4'd0, 0, 4'd9, 1, 0, 1);      // hazard + redirect
        n_total++; if (stall !== 1'b0) $display("FAIL redir_stall got %0b want 0", stall); else n_pass++;
        n_total++; if (flush_ifid !== 1'b1) $display("FAIL redir_flush got %0b want 1", flush_ifid); else n_pass++;
        tick(1);
        n_total++; if (ex_fwd1_sel !== 2'd0 || ex_fwd2_sel !== 2'd0)
            $display("FAIL redir_sel got %0d/%0d want 0/0", ex_fwd1_sel, ex_fwd2_sel); else n_pass++;
        // The flushed instruction wrote r9; if it had entered EX, r9 would forward.
        drive(1, 4'd9, 1, 4'd0, 0, 4'd10, 1, 0, 0);
        tick(1);
        n_total++; if (ex_fwd1_sel !== 2'd0) $display("FAIL redir_e1_invalid got %0d want 0", ex_fwd1_sel); else n_pass++;
        drain();
    endtask

    task automatic test_adv_hold();
        drive(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1, 0);      // LW r5
        tick(1);
        drive(1, 4'd1, 0, 4'd5, 1, 4'd6, 1, 0, 0);      // reads r5
        for (int i = 0; i < 5; i++) begin
            tick(0);
            n_total++; if (stall !== 1'b1) $display("FAIL hold_stall[%0d] got %0b want 1", i, stall); else n_pass++;
        end
        tick(1);
        n_total++; if (stall !== 1'b0) $display("FAIL hold_release got %0b want 0", stall); else n_pass++;
        tick(1);
        n_total++; if (ex_fwd2_sel !== 2'd3) $display("FAIL hold_sel2 got %0d want 3", ex_fwd2_sel); else n_pass++;
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 9) != 0,
                  4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            n_total++; if (stall !== exp_stall())
                $display("FAIL rnd_stall[%0d] got %0b want %0b", i, stall, exp_stall()); else n_pass++;
            n_total++; if (flush_ifid !== redirect)
                $display("FAIL rnd_flush[%0d] got %0b want %0b", i, flush_ifid, redirect); else n_pass++;
            tick($urandom_range(0, 3) != 0);
            n_total++; if (ex_fwd1_sel !== 2'(m_sel1) || ex_fwd2_sel !== 2'(m_sel2))
                $display("FAIL rnd_sel[%0d] got %0d/%0d want %0d/%0d", i, ex_fwd1_sel, ex_fwd2_sel, m_sel1, m_sel2);
            else n_pass++;
            n_total++; if (stall_cnt !== (STATS ? 16'(m_scnt) : 16'd0) || flush_cnt !== (STATS ? 16'(m_fcnt) : 16'd0))
                $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt,
                         STATS ? m_scnt : 0, STATS ? m_fcnt : 0);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        for (int n = 0; n < 3; n++) begin
            drive(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0);
            tick(1);
            drive(1, 4'd3, 1, 4'd0, 0, 4'd4, 1, 0, 0);
            tick(1);
            tick(1);
        end
        n_total++; if (stall_cnt !== (STATS ? 16'd3 : 16'd0))
            $display("FAIL mid_stall_cnt got %0d want %0d", stall_cnt, STATS ? 3 : 0); else n_pass++;
        drive(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 1, 0);
        tick(1);
        drive(1, 4'd7, 1, 4'd7, 1, 4'd8, 1, 0, 0);
        n_total++; if (stall !== 1'b1) $display("FAIL mid_pre_stall got %0b want 1", stall); else n_pass++;
        #1;
        RST = 1'b0;
        model_clear();
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL mid_stall_drop got %0b want 0", stall); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL mid_cnt_clear got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        n_total++; if (ex_fwd1_sel !== 2'd0 || ex_fwd2_sel !== 2'd0)
            $display("FAIL mid_sel_clear got %0d/%0d want 0/0", ex_fwd1_sel, ex_fwd2_sel); else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        n_total++; if (stall !== 1'b0) $display("FAIL mid_sb_empty got %0b want 0", stall); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_distance();
        test_redirect_load();
        test_adv_hold();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
